// File: rtl/fft_stage_sequencer.sv
// Address/control sequencer for an in-place radix-2 16-point FFT: bit-reversed
// load, per-stage butterfly read/write-back with a fixed-latency datapath, and unload.
module fft_stage_sequencer #(
    parameter int unsigned N        = 16,
    parameter int unsigned BFLY_LAT = 2,
    localparam int unsigned AW      = $clog2(N),
    localparam int unsigned KW      = $clog2(N / 2),
    localparam int unsigned SW      = $clog2(AW)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_inputs,
    input  logic          compute,
    input  logic [SW-1:0] stage,
    input  logic          read_sel,
    input  logic          write_sel,
    input  logic          done,
    input  logic          in_valid,
    output logic          in_ready,
    output logic          ld_wr_en,
    output logic          ld_bank,
    output logic [AW-1:0] ld_wr_addr,
    output logic          rd_en,
    output logic          rd_bank,
    output logic [AW-1:0] rd_addr_a,
    output logic [AW-1:0] rd_addr_b,
    output logic [KW-1:0] tw_idx,
    output logic          wr_en,
    output logic          wr_bank,
    output logic [AW-1:0] wr_addr_a,
    output logic [AW-1:0] wr_addr_b,
    input  logic          out_ready,
    output logic          ul_rd_en,
    output logic          ul_bank,
    output logic [AW-1:0] ul_addr,
    output logic          busy,
    output logic          stage_done,
    output logic          overrun
);

    typedef enum logic [2:0] {IDLE, LOAD, COMPUTE, DRAIN, UNLOAD} state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic [KW-1:0] k_q, k_d;
    logic [SW-1:0] s_q, s_d;
    logic          ld_bank_q, ld_bank_d;
    logic          rd_bank_q, rd_bank_d;
    logic          wr_bank_q, wr_bank_d;
    logic          ul_bank_q, ul_bank_d;
    logic          overrun_q, overrun_d;
    logic          stage_done_q, stage_done_d;

    // Write-back delay line: one entry per datapath cycle
    logic          pv_q [BFLY_LAT];
    logic [AW-1:0] pa_q [BFLY_LAT];
    logic [AW-1:0] pb_q [BFLY_LAT];

    logic [AW-1:0] half, lo, addr_a;
    logic [SW:0]   sh_hi;
    logic          pend;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            k_q          <= '0;
            s_q          <= '0;
            ld_bank_q    <= 1'b0;
            rd_bank_q    <= 1'b0;
            wr_bank_q    <= 1'b0;
            ul_bank_q    <= 1'b0;
            overrun_q    <= 1'b0;
            stage_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            k_q          <= k_d;
            s_q          <= s_d;
            ld_bank_q    <= ld_bank_d;
            rd_bank_q    <= rd_bank_d;
            wr_bank_q    <= wr_bank_d;
            ul_bank_q    <= ul_bank_d;
            overrun_q    <= overrun_d;
            stage_done_q <= stage_done_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(BFLY_LAT); i++) begin
                pv_q[i] <= 1'b0;
                pa_q[i] <= '0;
                pb_q[i] <= '0;
            end
        end else begin
            pv_q[0] <= rd_en;
            pa_q[0] <= rd_addr_a;
            pb_q[0] <= rd_addr_b;
            for (int i = 1; i < int'(BFLY_LAT); i++) begin
                pv_q[i] <= pv_q[i-1];
                pa_q[i] <= pa_q[i-1];
                pb_q[i] <= pb_q[i-1];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        k_d          = k_q;
        s_d          = s_q;
        ld_bank_d    = ld_bank_q;
        rd_bank_d    = rd_bank_q;
        wr_bank_d    = wr_bank_q;
        ul_bank_d    = ul_bank_q;
        overrun_d    = overrun_q;
        stage_done_d = 1'b0;
        in_ready     = 1'b0;
        ld_wr_en     = 1'b0;
        rd_en        = 1'b0;
        ul_rd_en     = 1'b0;

        // Butterfly k of stage s pairs a and a+2^s; twiddle scales with the group offset
        half   = AW'(1) << s_q;
        lo     = AW'(k_q) & (half - AW'(1));
        sh_hi  = {1'b0, s_q} + (SW+1)'(1);
        addr_a = ((AW'(k_q) >> s_q) << sh_hi) + lo;

        pend = 1'b0;
        for (int i = 0; i < int'(BFLY_LAT) - 1; i++) begin
            pend = pend | pv_q[i];
        end

        unique case (state_q)
            IDLE: begin
                if (load_inputs) begin
                    state_d   = LOAD;
                    ld_bank_d = read_sel;
                    cnt_d     = '0;
                end else if (compute) begin
                    state_d   = COMPUTE;
                    s_d       = stage;
                    rd_bank_d = read_sel;
                    wr_bank_d = write_sel;
                    k_d       = '0;
                end else if (done) begin
                    state_d   = UNLOAD;
                    ul_bank_d = write_sel;
                    cnt_d     = '0;
                end
            end
            LOAD: begin
                in_ready = 1'b1;
                ld_wr_en = in_valid;
                if (in_valid) begin
                    cnt_d = cnt_q + AW'(1);
                    if (cnt_q == AW'(N - 1)) state_d = IDLE;
                end
            end
            COMPUTE: begin
                rd_en = 1'b1;
                k_d   = k_q + KW'(1);
                if (k_q == KW'(N / 2 - 1)) state_d = DRAIN;
            end
            DRAIN: begin
                if (pv_q[BFLY_LAT-1] && !pend) begin
                    stage_done_d = 1'b1;
                    state_d      = IDLE;
                end
            end
            UNLOAD: begin
                ul_rd_en = out_ready;
                if (out_ready) begin
                    cnt_d = cnt_q + AW'(1);
                    if (cnt_q == AW'(N - 1)) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (state_q != IDLE && (load_inputs || compute || done)) overrun_d = 1'b1;

        for (int i = 0; i < int'(AW); i++) begin
            ld_wr_addr[i] = (state_q == LOAD) & cnt_q[AW-1-i];
        end
        ld_bank   = (state_q == LOAD) & ld_bank_q;
        rd_bank   = rd_en & rd_bank_q;
        rd_addr_a = rd_en ? addr_a : '0;
        rd_addr_b = rd_en ? addr_a + half : '0;
        tw_idx    = rd_en ? KW'(lo << (SW'(KW) - s_q)) : '0;
        wr_en     = pv_q[BFLY_LAT-1];
        wr_bank   = wr_en & wr_bank_q;
        wr_addr_a = pa_q[BFLY_LAT-1];
        wr_addr_b = pb_q[BFLY_LAT-1];
        ul_bank   = (state_q == UNLOAD) & ul_bank_q;
        ul_addr   = (state_q == UNLOAD) ? cnt_q : '0;
        busy      = (state_q != IDLE);
        stage_done = stage_done_q;
        overrun    = overrun_q;
    end

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// Scenario bench for fft_stage_sequencer: reset, load, stage compute, overrun,
// unload and mid-stage reset, with queue-based expected address sequences.
module tb_fft_stage_sequencer;

    localparam int LAT = 2;

    logic       clk = 1'b0;
    logic       rst, load_inputs, compute, read_sel, write_sel, done, in_valid, out_ready;
    logic [1:0] stage;
    logic       in_ready, ld_wr_en, ld_bank, rd_en, rd_bank, wr_en, wr_bank;
    logic       ul_rd_en, ul_bank, busy, stage_done, overrun;
    logic [3:0] ld_wr_addr, rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b, ul_addr;
    logic [2:0] tw_idx;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    bit ovr_exp  = 1'b0;

    typedef struct {
        int         cyc;
        logic [3:0] a;
        logic [3:0] b;
        logic [2:0] tw;
    } exp_t;

    exp_t       rdq[$];
    exp_t       wrq[$];
    logic [3:0] addrq[$];

    fft_stage_sequencer #(.N(16), .BFLY_LAT(LAT)) dut (
        .clk(clk), .rst(rst), .load_inputs(load_inputs), .compute(compute), .stage(stage),
        .read_sel(read_sel), .write_sel(write_sel), .done(done), .in_valid(in_valid),
        .in_ready(in_ready), .ld_wr_en(ld_wr_en), .ld_bank(ld_bank), .ld_wr_addr(ld_wr_addr),
        .rd_en(rd_en), .rd_bank(rd_bank), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .tw_idx(tw_idx), .wr_en(wr_en), .wr_bank(wr_bank), .wr_addr_a(wr_addr_a),
        .wr_addr_b(wr_addr_b), .out_ready(out_ready), .ul_rd_en(ul_rd_en), .ul_bank(ul_bank),
        .ul_addr(ul_addr), .busy(busy), .stage_done(stage_done), .overrun(overrun)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic clear_inputs();
        load_inputs = 0; compute = 0; stage = 0; read_sel = 0; write_sel = 0;
        done = 0; in_valid = 0; out_ready = 0;
    endtask

    task automatic rand_inputs();
        load_inputs = 1'($urandom); compute = 1'($urandom); stage = 2'($urandom);
        read_sel = 1'($urandom); write_sel = 1'($urandom); done = 1'($urandom);
        in_valid = 1'($urandom); out_ready = 1'($urandom);
    endtask

    task automatic test_reset();
        logic [38:0] allo;
        rst = 1'b1;
        rand_inputs();
        @(posedge clk);
        @(negedge clk);
        rand_inputs();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        allo = {in_ready, ld_wr_en, ld_bank, ld_wr_addr, rd_en, rd_bank, rd_addr_a, rd_addr_b,
                tw_idx, wr_en, wr_bank, wr_addr_a, wr_addr_b, ul_rd_en, ul_bank, ul_addr,
                busy, stage_done, overrun};
        checks++;
        if (allo !== '0) begin
            failures++;
            $display("FAIL reset_outputs got=%0h exp=0", allo);
        end
        checks++;
        if ({busy, overrun} !== 2'b00) begin
            failures++;
            $display("FAIL reset_busy_overrun got=%b exp=00", {busy, overrun});
        end
        clear_inputs();
    endtask

    task automatic test_load();
        int         sent = 0;
        bit         gap  = 1'b0;
        logic [3:0] c, e;
        for (int i = 0; i < 16; i++) begin
            c = 4'(i);
            addrq.push_back({c[0], c[1], c[2], c[3]});
        end
        @(negedge clk);
        load_inputs = 1'b1; read_sel = 1'b0; write_sel = 1'b1;
        @(negedge clk);
        load_inputs = 1'b0;
        for (int t = 0; t < 40 && sent < 16; t++) begin
            in_valid = !(sent == 5 && !gap);
            if (sent == 5) gap = 1'b1;
            #1;
            checks++;
            if (in_ready !== 1'b1 || busy !== 1'b1) begin
                failures++;
                $display("FAIL load_ready t=%0d got=%b%b exp=11", t, in_ready, busy);
            end
            checks++;
            if (ld_wr_en !== in_valid) begin
                failures++;
                $display("FAIL load_wr_en t=%0d got=%b exp=%b", t, ld_wr_en, in_valid);
            end
            if (in_valid) begin
                e = addrq.pop_front();
                checks++;
                if (ld_wr_addr !== e || ld_bank !== 1'b0) begin
                    failures++;
                    $display("FAIL load_addr n=%0d got=%0d/%b exp=%0d/0", sent, ld_wr_addr, ld_bank, e);
                end
                sent++;
            end
            @(negedge clk);
        end
        checks++;
        if (sent != 16) begin
            failures++;
            $display("FAIL load_timeout got=%0d exp=16", sent);
        end
        in_valid = 1'b1;
        #1;
        checks++;
        if ({in_ready, ld_wr_en, busy} !== 3'b000) begin
            failures++;
            $display("FAIL load_end got=%b exp=000", {in_ready, ld_wr_en, busy});
        end
        in_valid = 1'b0;
    endtask

    task automatic test_stage(input logic [1:0] s, input logic rsel, input logic wsel,
                              input int ovr_at, input int rst_at);
        int   c0, half, grp, j, set_ovr, clr_ovr, n_sd;
        bit   exp_rd, exp_wr, exp_sd, exp_busy;
        exp_t e;
        @(negedge clk);
        compute = 1'b1; stage = s; read_sel = rsel; write_sel = wsel;
        c0      = cyc;
        half    = 1 << s;
        set_ovr = -1;
        clr_ovr = -1;
        n_sd    = 0;
        for (int k = 0; k < 8; k++) begin
            grp  = k / half;
            j    = k % half;
            e.a  = 4'(grp * 2 * half + j);
            e.b  = 4'(grp * 2 * half + j + half);
            e.tw = 3'(j * 8 / half);
            e.cyc = c0 + 1 + k;
            if (rst_at < 0 || e.cyc <= c0 + rst_at) rdq.push_back(e);
            e.cyc = c0 + 1 + k + LAT;
            if (rst_at < 0 || e.cyc <= c0 + rst_at) wrq.push_back(e);
        end
        @(negedge clk);
        compute = 1'b0;
        while (cyc <= c0 + 12 + LAT) begin
            if (cyc == set_ovr) ovr_exp = 1'b1;
            if (cyc == clr_ovr) ovr_exp = 1'b0;
            exp_rd = rdq.size() > 0 && rdq[0].cyc == cyc;
            checks++;
            if (rd_en !== exp_rd) begin
                failures++;
                $display("FAIL stage%0d_rd_en cyc=%0d got=%b exp=%b", s, cyc - c0, rd_en, exp_rd);
            end else if (exp_rd) begin
                e = rdq[0];
                checks++;
                if ({rd_addr_a, rd_addr_b, tw_idx, rd_bank} !== {e.a, e.b, e.tw, rsel}) begin
                    failures++;
                    $display("FAIL stage%0d_rd cyc=%0d got=%0d,%0d,%0d,%b exp=%0d,%0d,%0d,%b", s,
                             cyc - c0, rd_addr_a, rd_addr_b, tw_idx, rd_bank, e.a, e.b, e.tw, rsel);
                end
            end
            if (exp_rd) void'(rdq.pop_front());
            exp_wr = wrq.size() > 0 && wrq[0].cyc == cyc;
            checks++;
            if (wr_en !== exp_wr) begin
                failures++;
                $display("FAIL stage%0d_wr_en cyc=%0d got=%b exp=%b", s, cyc - c0, wr_en, exp_wr);
            end else if (exp_wr) begin
                e = wrq[0];
                checks++;
                if ({wr_addr_a, wr_addr_b, wr_bank} !== {e.a, e.b, wsel}) begin
                    failures++;
                    $display("FAIL stage%0d_wr cyc=%0d got=%0d,%0d,%b exp=%0d,%0d,%b", s,
                             cyc - c0, wr_addr_a, wr_addr_b, wr_bank, e.a, e.b, wsel);
                end
            end
            if (exp_wr) void'(wrq.pop_front());
            exp_sd = (rst_at < 0) && (cyc == c0 + 9 + LAT);
            if (stage_done === 1'b1) n_sd++;
            checks++;
            if (stage_done !== exp_sd) begin
                failures++;
                $display("FAIL stage%0d_done cyc=%0d got=%b exp=%b", s, cyc - c0, stage_done, exp_sd);
            end
            exp_busy = (cyc >= c0 + 1) && (cyc <= c0 + 8 + LAT) && (rst_at < 0 || cyc <= c0 + rst_at);
            checks++;
            if (busy !== exp_busy || overrun !== ovr_exp) begin
                failures++;
                $display("FAIL stage%0d_busy_ovr cyc=%0d got=%b%b exp=%b%b", s, cyc - c0,
                         busy, overrun, exp_busy, ovr_exp);
            end
            compute = 1'b0;
            rst     = 1'b0;
            if (cyc - c0 == ovr_at) begin
                compute = 1'b1; stage = ~s; read_sel = ~rsel; write_sel = ~wsel;
                set_ovr = cyc + 1;
            end
            if (cyc - c0 == rst_at) begin
                rst     = 1'b1;
                compute = 1'b1;
                clr_ovr = cyc + 1;
            end
            @(negedge clk);
        end
        compute = 1'b0;
        rst     = 1'b0;
        checks++;
        if (rdq.size() != 0 || wrq.size() != 0 || n_sd != (rst_at < 0 ? 1 : 0)) begin
            failures++;
            $display("FAIL stage%0d_leftover got=%0d,%0d,%0d exp=0,0,%0d", s, rdq.size(),
                     wrq.size(), n_sd, rst_at < 0 ? 1 : 0);
        end
        rdq.delete();
        wrq.delete();
    endtask

    task automatic test_unload();
        int n = 0;
        @(negedge clk);
        done = 1'b1; write_sel = 1'b1; read_sel = 1'b0;
        @(negedge clk);
        done = 1'b0;
        for (int t = 0; t < 40 && n < 16; t++) begin
            out_ready = (t % 2 == 0);
            #1;
            checks++;
            if (ul_rd_en !== out_ready || busy !== 1'b1 || overrun !== ovr_exp) begin
                failures++;
                $display("FAIL unload_strobe t=%0d got=%b%b%b exp=%b1%b", t, ul_rd_en, busy,
                         overrun, out_ready, ovr_exp);
            end
            if (out_ready) begin
                checks++;
                if (ul_addr !== 4'(n) || ul_bank !== 1'b1) begin
                    failures++;
                    $display("FAIL unload_addr n=%0d got=%0d/%b exp=%0d/1", n, ul_addr, ul_bank, n);
                end
                n++;
            end
            @(negedge clk);
        end
        checks++;
        if (n != 16) begin
            failures++;
            $display("FAIL unload_timeout got=%0d exp=16", n);
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if ({ul_rd_en, ul_bank, busy} !== 3'b000) begin
            failures++;
            $display("FAIL unload_end got=%b exp=000", {ul_rd_en, ul_bank, busy});
        end
        out_ready = 1'b0;
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_load();
        test_stage(2'd0, 1'b0, 1'b1, -1, -1);
        test_stage(2'd3, 1'b1, 1'b0, -1, -1);
        test_stage(2'd1, 1'b1, 1'b0, -1, -1);
        test_stage(2'd2, 1'b0, 1'b1, 3, -1);
        test_unload();
        test_stage(2'd1, 1'b0, 1'b1, -1, 5);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fft_stage_sequencer.md
FFT_STAGE_SEQUENCER -- requirements
Module: fft_stage_sequencer

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- N, 16, transform size; fixed at 16, so 4 stages and 8 butterflies per stage.
- BFLY_LAT, 2, butterfly datapath latency in cycles from rd_en to the matching wr_en (1..4).

REQ-002 Reset is rst, synchronous, active-high. The clock is clk.

REQ-003 Ports, one per line: name  direction  width  meaning.
- clk  in  1  clock
- rst  in  1  sync active-high reset
- load_inputs  in  1  controller strobe: begin input load
- compute  in  1  controller strobe: run one stage
- stage  in  2  stage index, sampled with compute
- read_sel  in  1  controller source bank
- write_sel  in  1  controller destination bank
- done  in  1  controller strobe: transform finished, begin unload
- in_valid  in  1  input sample valid
- in_ready  out  1  sequencer accepts a sample
- ld_wr_en  out  1  sample-memory write strobe
- ld_bank  out  1  bank for load writes
- ld_wr_addr  out  4  load write address
- rd_en  out  1  butterfly operand read
- rd_bank  out  1  read bank
- rd_addr_a  out  4  upper operand address
- rd_addr_b  out  4  lower operand address
- tw_idx  out  3  twiddle ROM index
- wr_en  out  1  butterfly result write
- wr_bank  out  1  write bank
- wr_addr_a  out  4  upper result address
- wr_addr_b  out  4  lower result address
- out_ready  in  1  downstream accepts an output sample
- ul_rd_en  out  1  unload read strobe
- ul_bank  out  1  unload bank
- ul_addr  out  4  unload address
- busy  out  1  state is not IDLE
- stage_done  out  1  one-cycle pulse when a stage's writes are complete
- overrun  out  1  sticky: a strobe arrived while busy

Function
REQ-004 The block SHALL have exactly these states: IDLE, LOAD, COMPUTE, DRAIN, UNLOAD.

REQ-005 IDLE strobe handling:
- Priority, when several strobes are high together: load_inputs > compute > done.
- load_inputs -> LOAD; ld_bank <= read_sel; cnt <= 0.
- compute -> COMPUTE; latch stage as s; rd_bank <= read_sel; wr_bank <= write_sel; k <= 0.
- done -> UNLOAD; ul_bank <= write_sel; cnt <= 0.

REQ-006 LOAD behaviour:
- in_ready = 1 throughout LOAD.
- ld_wr_en = in_valid & in_ready, combinational.
- ld_wr_addr = bit-reverse(cnt).
- cnt increments on each handshake.
- After the 16th handshake -> IDLE, with in_ready low the next cycle.

REQ-007 COMPUTE issues one butterfly per cycle, k = 0..7, with rd_en = 1 on each of the 8 cycles.
- half = 1<<s
- rd_addr_a = ((k>>s)<<(s+1)) + (k & (half-1))
- rd_addr_b = rd_addr_a + half
- tw_idx = (k & (half-1)) << (3-s)
- After k = 7 -> DRAIN.

REQ-008 Write-back pipeline:
- wr_en SHALL assert exactly BFLY_LAT cycles after each rd_en.
- wr_addr_a and wr_addr_b equal the corresponding read addresses (in-place).
- Bank is wr_bank.

REQ-009 DRAIN and stage_done timing:
- stage_done pulses one cycle after the last wr_en, then the block returns to IDLE.
- Compute strobe at cycle 0: rd_en on cycles 1..8, wr_en on cycles 1+BFLY_LAT..8+BFLY_LAT, stage_done on cycle 9+BFLY_LAT.

REQ-010 UNLOAD behaviour:
- ul_rd_en = out_ready, combinational.
- ul_addr = cnt, natural order.
- cnt increments on each ul_rd_en.
- After the 16th ul_rd_en -> IDLE.

REQ-011 Strobes while busy:
- Any load_inputs, compute or done while busy = 1 SHALL be ignored and SHALL set overrun.
- overrun clears only on rst.
- The ignored strobe has no effect on addresses, counters or state.

REQ-012 Outputs not described for the current state SHALL be 0. All addresses are modulo 16 and never exceed 15.

REQ-013 busy SHALL go high the cycle after an accepted strobe and low in the cycle IDLE is re-entered.

Reset
REQ-014 On rst:
- State -> IDLE; cnt, k and all banks -> 0.
- All outputs 0, including in_ready, busy, stage_done and overrun.
- Write pipeline flushed; no wr_en after the reset cycle.

REQ-015 rst mid-operation SHALL take priority over any strobe in the same cycle. Any LOAD, COMPUTE, DRAIN or UNLOAD in progress is abandoned without stage_done.

Verification
REQ-016 Reset: rst for 2 cycles with random inputs -> every output 0 on the cycle after rst.

REQ-017 Load: load_inputs with read_sel = 0; 16 samples with an in_valid gap at sample 5.
- ld_wr_addr = 0,8,4,12,2,10,6,14,1,9,5,13,3,11,7,15.
- ld_bank = 0.
- in_ready low after the 16th sample.

REQ-018 Compute stage 0 and stage 3, BFLY_LAT = 2:
- s = 0: pairs (0,1),(2,3)..(14,15), tw_idx all 0.
- s = 3: pairs (0,8)..(7,15), tw_idx 0..7.
- wr_en 2 cycles after rd_en; stage_done on cycle 11.

REQ-019 Compute stage 1:
- Pairs (0,2),(1,3),(4,6),(5,7),(8,10),(9,11),(12,14),(13,15).
- tw_idx 0,4,0,4,0,4,0,4.
- rd_bank = read_sel and wr_bank = write_sel, as sampled.

REQ-020 Overrun: compute strobe on cycle 3 of a running stage.
- overrun = 1 and stays 1.
- Address sequence unchanged; a single stage_done.

REQ-021 Unload and mid-run reset:
- Unload: done with write_sel = 1 and out_ready toggling 1,0,1,... -> ul_addr 0..15, exactly 16 ul_rd_en, ul_bank = 1.
- Reset mid-run: rst on cycle 5 of COMPUTE -> no wr_en and no stage_done afterwards.
